// File: rtl/trng_sampler.sv
// ---------------------------------------------------------------------------
// trng_sampler
//
// Sampling controller for the TRNG ring-oscillator entropy sources.
// The two entropy bits are XOR-mixed into a register every clock. The mixed
// bit is sampled once every SAMPLE_CYCLES clocks. 32 samples are packed MSB
// first into a word, and the word is offered over a valid/ack handshake.
//
// Build option:
//   TRNG_SAMPLER_HEALTH_EN  - adds a repetition-count health test. When
//                             REP_LIMIT identical samples occur in a row,
//                             output is withheld and health_error is set
//                             until enable is dropped.
//                             Undefined: health_error is tied to 0 and the
//                             ERROR state does not exist.
//
// Parameters:
//   SAMPLE_CYCLES  clocks between samples (2..65535)
//   REP_LIMIT      run length that trips the health test (2..63)
//
// Ports:
//   clk           system clock, sole clock domain
//   reset_n       asynchronous active-low reset
//   enable        level: 1 = collect, 0 = abort and idle
//   entropy0/1    entropy bits, already registered on clk
//   data_ack      one-cycle pulse: consumer takes the word
//   data          collected word, stable while data_valid = 1
//   data_valid    data holds an unconsumed word
//   health_error  sticky health-test failure flag
//
// Handshake: data_valid rises together with a new data word. The word is
// consumed by a data_ack pulse sampled at a clock edge while data_valid is 1.
// data_valid falls on that same edge. data_ack is ignored at any other time.
//
// Debug: the FSM state is held in the signal 'state' of type state_t.
// ---------------------------------------------------------------------------
module trng_sampler #(
    parameter logic [15:0] SAMPLE_CYCLES = 16'h1000,
    parameter logic [5:0]  REP_LIMIT     = 6'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        entropy0,
    input  logic        entropy1,
    input  logic        data_ack,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        health_error
);

    localparam logic [15:0] RELOAD = SAMPLE_CYCLES - 16'd1;

`ifdef TRNG_SAMPLER_HEALTH_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VALID   = 2'd2,
        ERROR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VALID   = 2'd2
    } state_t;
`endif

    state_t      state;
    state_t      state_next;

    logic        mix_reg;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_next;
    // Only the 31 oldest bits need to be kept: the 32nd bit comes straight
    // from mix_reg when the word is completed.
    logic [30:0] acc;
    logic [30:0] acc_next;
    logic [31:0] data_next;
    logic        data_valid_next;

    logic        sample_event;
    logic        health_trip;

    assign sample_event = (state == COLLECT) && (cnt == 16'd0);

`ifdef TRNG_SAMPLER_HEALTH_EN
    logic [5:0]  rep_cnt;
    logic [5:0]  rep_cnt_next;
    logic [5:0]  rep_calc;
    logic        prev_bit;
    logic        prev_bit_next;
    logic        health_reg;
    logic        health_next;

    // Length of the current run of identical samples, including the sample
    // being taken now. A count of 0 means no previous sample exists, so the
    // first sample after idle always starts a new run of length 1.
    always_comb begin
        rep_calc = 6'd1;
        if ((rep_cnt != 6'd0) && (mix_reg == prev_bit)) begin
            if (rep_cnt == 6'd63) begin
                rep_calc = 6'd63;
            end else begin
                rep_calc = rep_cnt + 6'd1;
            end
        end
    end

    assign health_trip  = sample_event && (rep_calc >= REP_LIMIT);
    assign health_error = health_reg;
`else
    logic unused_rep_limit;

    assign unused_rep_limit = ^REP_LIMIT;
    assign health_trip      = 1'b0;
    assign health_error     = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mix_reg    <= 1'b0;
            cnt        <= 16'd0;
            bit_cnt    <= 5'd0;
            acc        <= 31'd0;
            data       <= 32'd0;
            data_valid <= 1'b0;
`ifdef TRNG_SAMPLER_HEALTH_EN
            rep_cnt    <= 6'd0;
            prev_bit   <= 1'b0;
            health_reg <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            mix_reg    <= entropy0 ^ entropy1;
            cnt        <= cnt_next;
            bit_cnt    <= bit_cnt_next;
            acc        <= acc_next;
            data       <= data_next;
            data_valid <= data_valid_next;
`ifdef TRNG_SAMPLER_HEALTH_EN
            rep_cnt    <= rep_cnt_next;
            prev_bit   <= prev_bit_next;
            health_reg <= health_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bit_cnt_next    = bit_cnt;
        acc_next        = acc;
        data_next       = data;
        data_valid_next = data_valid;
`ifdef TRNG_SAMPLER_HEALTH_EN
        rep_cnt_next    = rep_cnt;
        prev_bit_next   = prev_bit;
        health_next     = health_reg;
`endif

        if (!enable) begin
            // Abort wins over any ack or sample event in the same cycle.
            // data keeps its last value on purpose.
            state_next      = IDLE;
            cnt_next        = 16'd0;
            bit_cnt_next    = 5'd0;
            acc_next        = 31'd0;
            data_valid_next = 1'b0;
`ifdef TRNG_SAMPLER_HEALTH_EN
            rep_cnt_next    = 6'd0;
            prev_bit_next   = 1'b0;
            health_next     = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt_next     = RELOAD;
                    bit_cnt_next = 5'd0;
                    acc_next     = 31'd0;
                    state_next   = COLLECT;
                end

                COLLECT: begin
                    if (!sample_event) begin
                        cnt_next = cnt - 16'd1;
                    end else begin
                        cnt_next     = RELOAD;
                        acc_next     = {acc[29:0], mix_reg};
                        bit_cnt_next = bit_cnt + 5'd1;
`ifdef TRNG_SAMPLER_HEALTH_EN
                        rep_cnt_next  = rep_calc;
                        prev_bit_next = mix_reg;
`endif
                        if (health_trip) begin
                            // The partial word is dropped: data and
                            // data_valid are left untouched.
`ifdef TRNG_SAMPLER_HEALTH_EN
                            health_next = 1'b1;
                            state_next  = ERROR;
`endif
                        end else if (bit_cnt == 5'd31) begin
                            data_next       = {acc, mix_reg};
                            data_valid_next = 1'b1;
                            state_next      = VALID;
                        end
                    end
                end

                VALID: begin
                    // Sampling is paused and the counter is held until the
                    // word is taken.
                    if (data_ack) begin
                        data_valid_next = 1'b0;
                        cnt_next        = RELOAD;
                        state_next      = COLLECT;
                    end
                end

`ifdef TRNG_SAMPLER_HEALTH_EN
                ERROR: begin
                    // Parked until enable drops or reset.
                    state_next = ERROR;
                end
`endif

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_sampler.sv
// ---------------------------------------------------------------------------
// tb_trng_sampler
//
// Directed bench for trng_sampler with SAMPLE_CYCLES = 4 and REP_LIMIT = 8.
// Inputs are driven just after the falling clock edge; outputs are observed
// at the falling edge, half a cycle after the active rising edge.
// Each word is driven as a 32-bit pattern: for sample k the mixed bit is
// pattern[31-k], split into a random entropy1 and entropy0 = bit ^ entropy1.
// ---------------------------------------------------------------------------
module tb_trng_sampler;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        entropy0;
    logic        entropy1;
    logic        data_ack;
    logic [31:0] data;
    logic        data_valid;
    logic        health_error;

    int checks = 0;
    int errors = 0;

    trng_sampler #(
        .SAMPLE_CYCLES (16'd4),
        .REP_LIMIT     (6'd8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .entropy0     (entropy0),
        .entropy1     (entropy1),
        .data_ack     (data_ack),
        .data         (data),
        .data_valid   (data_valid),
        .health_error (health_error)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running required done");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives n samples of pat. Ends 3 cycles into the last sample window,
    // i.e. one clock before the edge that takes the last sample.
    task automatic drive_samples(input logic [31:0] pat, input int n, input logic poke_ack);
        for (int k = 0; k < n; k++) begin
            entropy1 = 1'($urandom_range(0, 1));
            entropy0 = pat[31-k] ^ entropy1;
            for (int t = 0; t < ((k == n - 1) ? 3 : 4); t++) begin
                data_ack = poke_ack && (t == 1);
                tick(1);
            end
            data_ack = 1'b0;
        end
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        entropy0 = 1'b0;
        entropy1 = 1'b0;
        data_ack = 1'b0;

        // Reset held with enable=1
        tick(3);
        check("reset_data", data, 32'h0);
        check("reset_valid", {31'd0, data_valid}, 32'd1 - 32'd1);
        check("reset_health", {31'd0, health_error}, 32'h0);

        // Release: next rising edge is E0
        reset_n = 1'b1;
        tick(1);
        drive_samples(32'hAAAA_AAAA, 32, 1'b0);
        check("w1_valid_early", {31'd0, data_valid}, 32'h0);
        tick(1);
        check("w1_valid_rise", {31'd0, data_valid}, 32'h1);
        check("w1_data", data, 32'hAAAA_AAAA);

        // Hold without ack: word must stay put
        for (int h = 0; h < 5; h++) begin
            for (int c = 0; c < 100; c++) begin
                entropy0 = 1'($urandom_range(0, 1));
                entropy1 = 1'($urandom_range(0, 1));
                tick(1);
            end
            check("hold_data", data, 32'hAAAA_AAAA);
            check("hold_valid", {31'd0, data_valid}, 32'h1);
        end

        // Late ack: data kept, next word after exactly 32*4 cycles
        ack_pulse();
        check("ack_clears_valid", {31'd0, data_valid}, 32'h0);
        check("ack_keeps_data", data, 32'hAAAA_AAAA);
        drive_samples(32'hCCCC_CCCC, 32, 1'b0);
        check("w2_valid_early", {31'd0, data_valid}, 32'h0);
        tick(1);
        check("w2_valid_rise", {31'd0, data_valid}, 32'h1);
        check("w2_data", data, 32'hCCCC_CCCC);

        // Ack on first valid cycle: spacing 32*4+1
        ack_pulse();
        check("b2b_ack_clears", {31'd0, data_valid}, 32'h0);
        drive_samples(32'hF0F0_F0F0, 32, 1'b0);
        check("w3_valid_early", {31'd0, data_valid}, 32'h0);
        tick(1);
        check("w3_valid_rise", {31'd0, data_valid}, 32'h1);
        check("w3_data", data, 32'hF0F0_F0F0);

        // Stray ack pulses during collection are ignored
        ack_pulse();
        drive_samples(32'h3333_3333, 32, 1'b1);
        check("w4_valid_early", {31'd0, data_valid}, 32'h0);
        tick(1);
        check("w4_valid_rise", {31'd0, data_valid}, 32'h1);
        check("w4_data", data, 32'h3333_3333);

        // Abort on the edge of the 17th sample, then a fresh word
        ack_pulse();
        drive_samples(32'h5555_5555, 17, 1'b0);
        enable = 1'b0;
        tick(1);
        check("abort_valid", {31'd0, data_valid}, 32'h0);
        check("abort_keeps_data", data, 32'h3333_3333);
        tick(2);
        enable = 1'b1;
        tick(1);
        drive_samples(32'h0F0F_0F0F, 32, 1'b0);
        check("w5_valid_early", {31'd0, data_valid}, 32'h0);
        tick(1);
        check("w5_valid_rise", {31'd0, data_valid}, 32'h1);
        check("w5_data", data, 32'h0F0F_0F0F);

        // enable=0 together with data_ack
        enable   = 1'b0;
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        check("abort_ack_valid", {31'd0, data_valid}, 32'h0);
        check("abort_ack_data", data, 32'h0F0F_0F0F);
        tick(2);
        check("idle_valid", {31'd0, data_valid}, 32'h0);

        // Asynchronous reset mid-collection
        enable = 1'b1;
        tick(50);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", data, 32'h0);
        check("async_rst_valid", {31'd0, data_valid}, 32'h0);
        check("async_rst_health", {31'd0, health_error}, 32'h0);

        // Constant stimulus: mixed bit always 0
        @(negedge clk);
        entropy0 = 1'b1;
        entropy1 = 1'b1;
        reset_n  = 1'b1;
        tick(1);
`ifdef TRNG_SAMPLER_HEALTH_EN
        tick(31);
        check("health_before_trip", {31'd0, health_error}, 32'h0);
        tick(1);
        check("health_trip", {31'd0, health_error}, 32'h1);
        tick(200);
        check("health_no_valid", {31'd0, data_valid}, 32'h0);
        check("health_sticky", {31'd0, health_error}, 32'h1);
        enable = 1'b0;
        tick(1);
        check("health_clear", {31'd0, health_error}, 32'h0);
`else
        tick(127);
        check("const_valid_early", {31'd0, data_valid}, 32'h0);
        tick(1);
        check("const_valid_rise", {31'd0, data_valid}, 32'h1);
        check("const_data", data, 32'h0);
        check("const_health", {31'd0, health_error}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
